// File: rtl/control_unit.sv
// Single-cycle-style main control decoder with a registered output stage.
// The OpCode sampled at each rising edge is decoded and presented one cycle later.
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] OpCode,
  output logic       RegDst,
  output logic       ALUSrc,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Branch,
  output logic [1:0] ALUOp,
  output logic       Illegal
);

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  localparam logic [2:0] OpRType = 3'b000;
  localparam logic [2:0] OpLogI  = 3'b001;
  localparam logic [2:0] OpLw    = 3'b100;
  localparam logic [2:0] OpSw    = 3'b101;
  localparam logic [2:0] OpBeq   = 3'b110;
  localparam logic [2:0] OpAddI  = 3'b111;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;
  localparam logic [1:0] AluLogic = 2'b11;

  ctrl_t ctrl_d, ctrl_q;

  // Unlisted opcodes, and any X/Z in simulation, fall through to the illegal tuple.
  always_comb begin
    ctrl_d = '0;
    case (OpCode)
      OpRType: begin
        ctrl_d.reg_dst   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = AluFunct;
      end
      OpLw: begin
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.alu_op     = AluAdd;
      end
      OpSw: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_op    = AluAdd;
      end
      OpBeq: begin
        ctrl_d.branch = 1'b1;
        ctrl_d.alu_op = AluSub;
      end
      OpAddI: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = AluAdd;
      end
      OpLogI: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = AluLogic;
      end
      default: begin
        ctrl_d.illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  always_comb begin
    RegDst   = ctrl_q.reg_dst;
    ALUSrc   = ctrl_q.alu_src;
    MemtoReg = ctrl_q.mem_to_reg;
    RegWrite = ctrl_q.reg_write;
    MemRead  = ctrl_q.mem_read;
    MemWrite = ctrl_q.mem_write;
    Branch   = ctrl_q.branch;
    ALUOp    = ctrl_q.alu_op;
    Illegal  = ctrl_q.illegal;
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: table-lookup reference model checked every
// cycle, plus directed literal checks for reset, latency and mid-cycle changes.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] OpCode = 3'b000;
  logic       RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Illegal;
  logic [1:0] ALUOp;

  int n_cmp = 0;
  int n_bad = 0;
  bit running = 1'b0;

  control_unit dut (
    .clk      (clk),
    .reset    (reset),
    .OpCode   (OpCode),
    .RegDst   (RegDst),
    .ALUSrc   (ALUSrc),
    .MemtoReg (MemtoReg),
    .RegWrite (RegWrite),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Branch   (Branch),
    .ALUOp    (ALUOp),
    .Illegal  (Illegal)
  );

  always #5 clk = ~clk;

  // Tuple order: RegDst ALUSrc MemtoReg RegWrite MemRead MemWrite Branch ALUOp[1:0] Illegal
  localparam logic [9:0] TupR    = 10'b1001000_10_0;
  localparam logic [9:0] TupLw   = 10'b0111100_00_0;
  localparam logic [9:0] TupSw   = 10'b0100010_00_0;
  localparam logic [9:0] TupBeq  = 10'b0000001_01_0;
  localparam logic [9:0] TupAddI = 10'b0101000_00_0;
  localparam logic [9:0] TupLogI = 10'b0101000_11_0;
  localparam logic [9:0] TupIll  = 10'b0000000_00_1;

  logic [9:0] decode_tbl [8];
  initial begin
    decode_tbl[0] = TupR;
    decode_tbl[1] = TupLogI;
    decode_tbl[2] = TupIll;
    decode_tbl[3] = TupIll;
    decode_tbl[4] = TupLw;
    decode_tbl[5] = TupSw;
    decode_tbl[6] = TupBeq;
    decode_tbl[7] = TupAddI;
  end

  logic [9:0] outs;
  assign outs = {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, Illegal};

  // Reference: outputs are whatever the previous edge's OpCode maps to, or zero under reset.
  logic [9:0] model_q = '0;
  always @(posedge clk or posedge reset) begin
    if (reset) model_q <= '0;
    else if ($isunknown(OpCode)) model_q <= TupIll;
    else model_q <= decode_tbl[OpCode];
  end

  always @(negedge clk) begin
    if (running) begin
      n_cmp++;
      if (outs !== (reset ? 10'b0 : model_q)) begin
        n_bad++;
        $display("FAIL model op=%b got=%b want=%b t=%0t", OpCode, outs,
                 reset ? 10'b0 : model_q, $time);
      end
      n_cmp++;
      if (MemRead && MemWrite) begin
        n_bad++;
        $display("FAIL rd_wr_excl got=%b want=no both t=%0t", outs, $time);
      end
      n_cmp++;
      if (RegWrite && MemWrite) begin
        n_bad++;
        $display("FAIL regwr_memwr_excl got=%b want=no both t=%0t", outs, $time);
      end
      n_cmp++;
      if (Branch && (RegWrite || MemRead || MemWrite)) begin
        n_bad++;
        $display("FAIL branch_excl got=%b want=no side effects t=%0t", outs, $time);
      end
    end
  end

  task automatic check(input string name, input logic [9:0] want);
    n_cmp++;
    if (outs !== want) begin
      n_bad++;
      $display("FAIL %s got=%b want=%b t=%0t", name, outs, want, $time);
    end
  endtask

  // Present op between edges, let one edge capture it, then settle.
  task automatic apply(input logic [2:0] op);
    OpCode = op;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1 check("reset_async", 10'b0);
    running = 1'b1;
    @(posedge clk); #2;
    check("reset_hold", 10'b0);
    @(posedge clk); #2;
    reset = 1'b0;

    apply(3'b000); check("rtype", TupR);
    apply(3'b100); check("lw", TupLw);
    apply(3'b101); check("sw", TupSw);
    apply(3'b111); check("addi", TupAddI);
    apply(3'b110); check("beq", TupBeq);
    apply(3'b001); check("logi", TupLogI);
    apply(3'b010); check("ill_010", TupIll);
    apply(3'b011); check("ill_011", TupIll);

    apply(3'b100); check("lw_before_change", TupLw);
    OpCode = 3'b101;
    #2 check("lw_held_mid_cycle", TupLw);
    @(posedge clk); #2;
    check("sw_after_edge", TupSw);

    apply(3'b100); check("lw_steady", TupLw);
    reset = 1'b1;
    #1 check("reset_mid_stream", 10'b0);
    @(posedge clk); #2;
    check("reset_over_edge", 10'b0);
    reset = 1'b0;
    #1 check("released_before_edge", 10'b0);
    @(posedge clk); #2;
    check("lw_after_release", TupLw);

    apply(3'b000);
    apply(3'b000); check("rtype_hold", TupR);

    for (int i = 0; i < 1000; i++) begin
      apply(3'($urandom_range(0, 7)));
    end
    @(negedge clk);
    running = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
